// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel event synchroniser.
package sync_pkg;

   localparam int unsigned MODE_TOGGLE = 0;
   localparam int unsigned MODE_RISE   = 1;

   // Smallest r with 2**r >= v.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned chw(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/sync_event_ch.sv
// One event channel: synchroniser, edge detect, saturating pending count, sticky overflow.
module sync_event_ch
   import sync_pkg::*;
#(
   parameter int unsigned NSYNC = 2,
   parameter int unsigned CNTW  = 4,
   parameter int unsigned MODE  = MODE_TOGGLE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_lvl,
   input  logic            arm,
   input  logic            served,
   input  logic            ovf_clr,
   output logic [CNTW-1:0] pend,
   output logic            ovf
);

   localparam logic [CNTW-1:0] PEND_MAX = '1;

   logic [NSYNC-1:0] sync_q;
   logic             prev_q;
   logic [CNTW-1:0]  pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic             sync_c;
   logic             event_c;

   assign sync_c = sync_q[NSYNC-1];

   // prev keeps tracking while disarmed, so arming never sees a stale edge.
   always_comb begin
      event_c = 1'b0;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      if (arm) begin
         if (MODE == MODE_RISE) event_c = sync_c & ~prev_q;
         else                   event_c = sync_c ^ prev_q;
      end
      if (ovf_clr) ovf_d = 1'b0;
      if (event_c && !served) begin
         if (pend_q == PEND_MAX) ovf_d  = 1'b1;
         else                    pend_d = pend_q + CNTW'(1);
      end else if (served && !event_c && (pend_q != '0)) begin
         pend_d = pend_q - CNTW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         pend_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[NSYNC-2:0], in_lvl};
         prev_q <= sync_c;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   assign pend = pend_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/sync_event_arb.sv
// Multi-channel event synchroniser with a round-robin valid/ready output port.
module sync_event_arb
   import sync_pkg::*;
#(
   parameter  int unsigned NCH   = 4,
   parameter  int unsigned NSYNC = 2,
   parameter  int unsigned CNTW  = 4,
   parameter  int unsigned MODE  = MODE_TOGGLE,
   localparam int unsigned CHW   = chw(NCH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NCH-1:0]      in_lvl,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CHW-1:0]      out_ch,
   output logic [NCH*CNTW-1:0] pend,
   output logic [NCH-1:0]      ovf,
   input  logic [NCH-1:0]      ovf_clr
);

   localparam int unsigned     ARMW    = clog2(NSYNC + 2);
   localparam logic [ARMW-1:0] ARM_END = ARMW'(NSYNC + 1);

   logic [ARMW-1:0] arm_cnt_q, arm_cnt_d;
   logic            arm_c;
   logic            out_valid_q, out_valid_d;
   logic [CHW-1:0]  out_ch_q, out_ch_d;
   logic [CHW-1:0]  last_q, last_d;
   logic            hs_c;
   logic [NCH-1:0]  served_c;
   logic [NCH-1:0]  avail_c;
   logic [CNTW-1:0] pend_w [NCH];

   assign arm_c = (arm_cnt_q == ARM_END);
   assign hs_c  = out_valid_q & out_ready;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign served_c[i] = hs_c & (out_ch_q == CHW'(i));
      // A channel still has work after this cycle's accept is taken out.
      assign avail_c[i]  = (pend_w[i] > CNTW'(1)) ||
                           ((pend_w[i] == CNTW'(1)) && !served_c[i]);

      sync_event_ch #(
         .NSYNC (NSYNC),
         .CNTW  (CNTW),
         .MODE  (MODE)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .in_lvl  (in_lvl[i]),
         .arm     (arm_c),
         .served  (served_c[i]),
         .ovf_clr (ovf_clr[i]),
         .pend    (pend_w[i]),
         .ovf     (ovf[i])
      );

      assign pend[i*CNTW +: CNTW] = pend_w[i];
   end

   // Round-robin pick starting after the last granted channel.
   always_comb begin
      int unsigned idx;
      logic        found;
      idx         = 0;
      found       = 1'b0;
      arm_cnt_d   = arm_c ? arm_cnt_q : arm_cnt_q + ARMW'(1);
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      last_d      = last_q;
      for (int unsigned k = 1; k <= NCH; k++) begin
         idx = (int'(last_q) + k) % NCH;
         if (!found && avail_c[idx[CHW-1:0]]) begin
            found    = 1'b1;
            out_ch_d = idx[CHW-1:0];
         end
      end
      if (found && (!out_valid_q || hs_c)) begin
         out_valid_d = 1'b1;
         last_d      = out_ch_d;
      end else begin
         out_ch_d = out_ch_q;
         if (hs_c) out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         arm_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         last_q      <= CHW'(NCH - 1);
      end else begin
         arm_cnt_q   <= arm_cnt_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         last_q      <= last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_sync_event_arb.sv
// Randomised scoreboard bench for sync_event_arb against a delay-history reference model.
module tb_sync_event_arb;

   localparam int NCH   = 4;
   localparam int NSYNC = 2;
   localparam int CNTW  = 2;
   localparam int MODE  = 0;
   localparam int PMAX  = (1 << CNTW) - 1;
   localparam int CHW   = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NCH-1:0]      in_lvl = '0;
   logic [NCH-1:0]      ovf_clr = '0;
   logic                out_ready = 1'b0;
   logic                out_valid;
   logic [CHW-1:0]      out_ch;
   logic [NCH*CNTW-1:0] pend;
   logic [NCH-1:0]      ovf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sync_event_arb #(.NCH(NCH), .NSYNC(NSYNC), .CNTW(CNTW), .MODE(MODE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_lvl    (in_lvl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .pend      (pend),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pend_of(input int ch);
      return int'(pend[ch*CNTW +: CNTW]);
   endfunction

   // Reference model: each input seen NSYNC edges late, events counted once armed.
   int             m_pend [NCH];
   bit             m_ovf  [NCH];
   bit             m_vld;
   int             m_ch;
   int             m_last;
   int             m_age;
   logic [NCH-1:0] m_hist [NSYNC+1];
   int             exp_q  [$];

   always @(posedge clk) begin
      logic [NCH-1:0] s, p;
      bit             armed, hs, ev, any;
      bit             avail [NCH];
      int             served, pick;
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 0;
            m_ovf[i]  = 0;
         end
         for (int j = 0; j <= NSYNC; j++) m_hist[j] = '0;
         m_vld  = 0;
         m_ch   = 0;
         m_last = NCH - 1;
         m_age  = 0;
      end else begin
         s      = m_hist[NSYNC-1];
         p      = m_hist[NSYNC];
         armed  = (m_age >= NSYNC + 1);
         hs     = m_vld && out_ready;
         served = hs ? m_ch : -1;
         for (int i = 0; i < NCH; i++)
            avail[i] = (m_pend[i] - ((served == i) ? 1 : 0)) > 0;
         for (int i = 0; i < NCH; i++) begin
            ev = armed && ((MODE == 0) ? (s[i] != p[i]) : (s[i] && !p[i]));
            if (ovf_clr[i]) m_ovf[i] = 0;
            if (ev && served != i) begin
               if (m_pend[i] == PMAX) m_ovf[i] = 1;
               else m_pend[i]++;
            end else if (!ev && served == i && m_pend[i] > 0) begin
               m_pend[i]--;
            end
         end
         any  = 0;
         pick = m_last;
         for (int k = 1; k <= NCH; k++) begin
            int j;
            j = (m_last + k) % NCH;
            if (!any && avail[j]) begin
               any  = 1;
               pick = j;
            end
         end
         if (any && (!m_vld || hs)) begin
            m_vld  = 1;
            m_ch   = pick;
            m_last = pick;
         end else if (hs) begin
            m_vld = 0;
         end
         for (int j = NSYNC; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = in_lvl;
         if (m_age < 1000) m_age++;
      end
   end

   // Expected accepts enter the scoreboard one half-cycle before the handshake edge.
   always @(negedge clk) begin
      if (m_vld && out_ready) exp_q.push_back(m_ch);
   end

   // Monitor: every DUT handshake must match the next expected channel.
   always @(negedge clk) begin
      int e;
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_accept", int'(out_ch), -1);
         end else begin
            e = exp_q.pop_front();
            chk("accept_ch", int'(out_ch), e);
         end
      end
   end

   // Per-cycle state comparison against the model.
   always @(negedge clk) begin
      #2;
      chk("out_valid", int'(out_valid), int'(m_vld));
      if (m_vld) chk("out_ch", int'(out_ch), m_ch);
      for (int i = 0; i < NCH; i++) begin
         chk("pend", pend_of(i), m_pend[i]);
         chk("ovf", int'(ovf[i]), int'(m_ovf[i]));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int last_tg [NCH];
      int cyc;

      // Arming: inputs high through reset must not produce events.
      in_lvl = 4'b1111;
      rst_n  = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(20);
      chk("arm_valid", int'(out_valid), 0);
      chk("arm_pend", int'(pend), 0);

      // Round-robin: simultaneous events on 0, 1, 3 served in order.
      out_ready = 1'b1;
      in_lvl    = in_lvl ^ 4'b1011;
      tick(4);
      chk("rr0_valid", int'(out_valid), 1);
      chk("rr0_ch", int'(out_ch), 0);
      tick(1);
      chk("rr1_ch", int'(out_ch), 1);
      tick(1);
      chk("rr3_ch", int'(out_ch), 3);
      tick(1);
      chk("rr_drain", int'(out_valid), 0);
      in_lvl[0] = ~in_lvl[0];
      tick(4);
      chk("rr_wrap_ch", int'(out_ch), 0);
      tick(4);

      // Latency on ch2 with an idle arbiter.
      in_lvl[2] = ~in_lvl[2];
      tick(3);
      chk("lat_early_valid", int'(out_valid), 0);
      chk("lat_pend_up", pend_of(2), 1);
      tick(1);
      chk("lat_valid", int'(out_valid), 1);
      chk("lat_ch", int'(out_ch), 2);
      tick(1);
      chk("lat_pend_down", pend_of(2), 0);
      chk("lat_valid_drop", int'(out_valid), 0);
      tick(4);

      // Back-pressure: three events on ch1 held, then drained.
      out_ready = 1'b0;
      repeat (3) begin
         in_lvl[1] = ~in_lvl[1];
         tick(4);
      end
      tick(2);
      chk("bp_pend", pend_of(1), 3);
      chk("bp_hold_ch", int'(out_ch), 1);
      chk("bp_hold_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      tick(3);
      chk("bp_drained_pend", pend_of(1), 0);
      chk("bp_drained_valid", int'(out_valid), 0);
      tick(4);

      // Overflow on ch0, clear racing with an event, then a lone clear.
      out_ready = 1'b0;
      repeat (4) begin
         in_lvl[0] = ~in_lvl[0];
         tick(4);
      end
      chk("ovf_pend_sat", pend_of(0), PMAX);
      chk("ovf_set", int'(ovf[0]), 1);
      in_lvl[0] = ~in_lvl[0];
      tick(2);
      ovf_clr[0] = 1'b1;
      tick(1);
      ovf_clr[0] = 1'b0;
      chk("ovf_set_wins", int'(ovf[0]), 1);
      tick(3);
      ovf_clr[0] = 1'b1;
      tick(1);
      ovf_clr[0] = 1'b0;
      chk("ovf_cleared", int'(ovf[0]), 0);
      out_ready = 1'b1;
      tick(8);

      // Random traffic with a mid-run reset.
      for (int i = 0; i < NCH; i++) last_tg[i] = 0;
      cyc = 0;
      repeat (1500) begin
         cyc++;
         for (int i = 0; i < NCH; i++) begin
            if ((cyc - last_tg[i]) >= NSYNC + 2 && $urandom_range(0, 4) == 0) begin
               in_lvl[i]  = ~in_lvl[i];
               last_tg[i] = cyc;
            end
            ovf_clr[i] = ($urandom_range(0, 19) == 0);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rst_n     = !(cyc >= 700 && cyc < 703);
         tick(1);
      end

      ovf_clr   = '0;
      out_ready = 1'b1;
      tick(20);
      chk("final_idle", int'(out_valid), 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
